// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state encoding, dimension record and default widths for the matmul sequencer
package matmul_pkg;

   localparam int DIM_W_DEF     = 4;
   localparam int DATA_W_DEF    = 4;
   localparam int ACC_W_DEF     = 32;
   localparam int MAX_ELEMS_DEF = 8;

   typedef enum logic [2:0] {IDLE, CHECK, RUN, DRAIN, DONE, ERR} seq_state_t;

   typedef struct packed {
      logic [DIM_W_DEF-1:0] r1;
      logic [DIM_W_DEF-1:0] c1;
      logic [DIM_W_DEF-1:0] r2;
      logic [DIM_W_DEF-1:0] c2;
   } dims_t;

endpackage

// File: rtl/matmul_idx_counter.sv
// rtl/matmul_idx_counter.sv - nested i/j/k loop counter with terminal count and operand/result address generation
module matmul_idx_counter
   import matmul_pkg::*;
#(
   parameter int DIM_W  = DIM_W_DEF,
   parameter int ADDR_W = 3
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              clear,
   input  logic              advance,
   input  logic [DIM_W-1:0]  r1,
   input  logic [DIM_W-1:0]  c1,
   input  logic [DIM_W-1:0]  c2,
   output logic [ADDR_W-1:0] a_addr,
   output logic [ADDR_W-1:0] b_addr,
   output logic [ADDR_W-1:0] res_addr,
   output logic              first_k,
   output logic              last_k,
   output logic              last
);

   localparam int AW = ADDR_W + DIM_W;

   logic [DIM_W-1:0] i, j, k;
   logic             i_end, j_end;

   assign first_k = (k == '0);
   assign last_k  = (k == c1 - DIM_W'(1));
   assign j_end   = (j == c2 - DIM_W'(1));
   assign i_end   = (i == r1 - DIM_W'(1));
   assign last    = i_end && j_end && last_k;

   // Full-width products, truncated only at the port; valid dims keep them in range.
   assign a_addr   = ADDR_W'(AW'(i) * AW'(c1) + AW'(k));
   assign b_addr   = ADDR_W'(AW'(k) * AW'(c2) + AW'(j));
   assign res_addr = ADDR_W'(AW'(i) * AW'(c2) + AW'(j));

   always_ff @(posedge CLK) begin
      if (RST || clear) begin
         i <= '0;
         j <= '0;
         k <= '0;
      end else if (advance) begin
         if (last_k) begin
            k <= '0;
            if (j_end) begin
               j <= '0;
               i <= i_end ? '0 : i + DIM_W'(1);
            end else begin
               j <= j + DIM_W'(1);
            end
         end else begin
            k <= k + DIM_W'(1);
         end
      end
   end

endmodule

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - validates matrix dims, walks i/j/k, accumulates products and writes results
// Optional cycle_cnt output enabled by MATMUL_SEQ_CYCLE_CNT_EN.
module matmul_sequencer
   import matmul_pkg::*;
#(
   parameter int DIM_W     = DIM_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ACC_W     = ACC_W_DEF,
   parameter int MAX_ELEMS = MAX_ELEMS_DEF,
   parameter int ADDR_W    = 3
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic [DIM_W-1:0]  r1,
   input  logic [DIM_W-1:0]  c1,
   input  logic [DIM_W-1:0]  r2,
   input  logic [DIM_W-1:0]  c2,
   output logic [ADDR_W-1:0] a_addr,
   output logic [ADDR_W-1:0] b_addr,
   output logic              rd_en,
   input  logic [DATA_W-1:0] a_data,
   input  logic [DATA_W-1:0] b_data,
   output logic [ADDR_W-1:0] res_addr,
   output logic [ACC_W-1:0]  res_data,
   output logic              res_we,
   output logic              busy,
   output logic              done,
   output logic              err
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
   ,
   output logic [15:0]       cycle_cnt
`endif
);

   localparam logic [2*DIM_W-1:0] MAX_SZ = (2*DIM_W)'(MAX_ELEMS);

   function automatic logic [2*DIM_W-1:0] dim_prod(input logic [DIM_W-1:0] x, input logic [DIM_W-1:0] y);
      return (2*DIM_W)'(x) * (2*DIM_W)'(y);
   endfunction

   seq_state_t        state;
   dims_t             d;
   logic [ADDR_W-1:0] issue_res_addr, ret_addr;
   logic              first_k, last_k, last_issue;
   logic              ret_valid, ret_first, ret_last;
   logic [ACC_W-1:0]  acc, prod, acc_next;
   logic              dims_bad;

   matmul_idx_counter #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) u_idx (
      .CLK      (CLK),
      .RST      (RST),
      .clear    (state == CHECK),
      .advance  (state == RUN),
      .r1       (d.r1),
      .c1       (d.c1),
      .c2       (d.c2),
      .a_addr   (a_addr),
      .b_addr   (b_addr),
      .res_addr (issue_res_addr),
      .first_k  (first_k),
      .last_k   (last_k),
      .last     (last_issue)
   );

   assign dims_bad = (d.r1 == '0) || (d.c1 == '0) || (d.r2 == '0) || (d.c2 == '0) ||
                     (d.c1 != d.r2) ||
                     (dim_prod(d.r1, d.c1) > MAX_SZ) ||
                     (dim_prod(d.r2, d.c2) > MAX_SZ) ||
                     (dim_prod(d.r1, d.c2) > MAX_SZ);

   assign prod     = ACC_W'(a_data) * ACC_W'(b_data);
   assign acc_next = ret_first ? prod : acc + prod;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         d         <= '0;
         rd_en     <= 1'b0;
         res_we    <= 1'b0;
         res_data  <= '0;
         res_addr  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         acc       <= '0;
         ret_valid <= 1'b0;
         ret_first <= 1'b0;
         ret_last  <= 1'b0;
         ret_addr  <= '0;
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
         cycle_cnt <= '0;
`endif
      end else begin
         res_we <= 1'b0;
         done   <= 1'b0;

         // Loop flags travel one cycle behind the issue so they line up with returned data.
         ret_valid <= rd_en;
         ret_first <= first_k;
         ret_last  <= last_k;
         ret_addr  <= issue_res_addr;

         if (ret_valid) begin
            acc <= acc_next;
            if (ret_last) begin
               res_we   <= 1'b1;
               res_data <= acc_next;
               res_addr <= ret_addr;
            end
         end

`ifdef MATMUL_SEQ_CYCLE_CNT_EN
         if (busy && cycle_cnt != 16'hFFFF)
            cycle_cnt <= cycle_cnt + 16'd1;
`endif

         case (state)
            IDLE: begin
               if (start) begin
                  d     <= {r1, c1, r2, c2};
                  err   <= 1'b0;
                  busy  <= 1'b1;
                  state <= CHECK;
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
                  cycle_cnt <= '0;
`endif
               end
            end
            CHECK: begin
               if (dims_bad) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= ERR;
               end else begin
                  rd_en <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               if (last_issue) begin
                  rd_en <= 1'b0;
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // The final write is the one with no return still in flight behind it.
               if (res_we && !ret_valid) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Controller that sequences the matrix multiply once both operand buffers are loaded.
- Latches dimensions R1/C1/R2/C2, validates them, then walks i/j/k loops.
- Issues read addresses to the operand buffers, accumulates products, and writes each result element to the result buffer.
- Sits between the stream loader (start, dims) and the operand/result storage; reports busy/done/err.

Parameters:
- DIM_W, 4, width of each dimension field
- DATA_W, 4, operand element width (unsigned)
- ACC_W, 32, accumulator/result element width
- MAX_ELEMS, 8, entries per operand/result buffer
- ADDR_W, 3, buffer address width; must satisfy 2^ADDR_W >= MAX_ELEMS

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- start  in  1  request pulse; honoured only in IDLE
- r1, c1, r2, c2  in  DIM_W each  dimensions; sampled only when start is accepted
- a_addr  out  ADDR_W  matrix_1 read address, i*C1+k
- b_addr  out  ADDR_W  matrix_2 read address, k*C2+j
- rd_en  out  1  read strobe; operand data is valid the next cycle
- a_data  in  DATA_W  matrix_1 read data
- b_data  in  DATA_W  matrix_2 read data
- res_addr  out  ADDR_W  result write address, i*C2+j
- res_data  out  ACC_W  result value
- res_we  out  1  result write strobe
- busy  out  1  high from CHECK through DONE inclusive
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky error flag; cleared by the next accepted start or by RST

Behaviour:
- One clock, CLK. Reset is synchronous, active-high, on RST.
- Reset values: all outputs 0, state IDLE, counters and accumulator 0.
- RST mid-operation aborts immediately with no further res_we.
- States: IDLE, CHECK, RUN, DRAIN, DONE, ERR.
- IDLE:
  - start=1 latches dims, clears err, moves to CHECK.
  - If start=1 coincides with RST, RST wins.
- CHECK (1 cycle):
  - Error if any dim is 0, or C1!=R2, or R1*C1>MAX_ELEMS, or R2*C2>MAX_ELEMS, or R1*C2>MAX_ELEMS.
  - On error go to ERR; otherwise clear i, j, k and go to RUN.
- RUN:
  - Every cycle: rd_en=1 and one (i,j,k) issued.
  - k increments; on k wrap, j increments; on j wrap, i increments.
  - The issue with i=R1-1, j=C2-1, k=C1-1 moves to DRAIN.
  - N = R1*C2*C1 issue cycles; no stalls.
- Operand return, one cycle after issue, with k==0 and k==C1-1 flags and res_addr pipelined alongside:
  - product = a_data*b_data, unsigned, zero-extended to ACC_W.
  - First k: acc <= product. Otherwise: acc <= acc + product, wrapping mod 2^ACC_W.
  - Last k: in the following cycle, res_we=1, res_data = final acc, res_addr = i*C2+j.
  - When C1=1, first and last coincide: acc is loaded and written.
- DRAIN: waits for the final return and final res_we, then moves to DONE.
- DONE (1 cycle): done=1, then IDLE. busy deasserts in the same cycle DONE exits.
- ERR (1 cycle): err=1 set (sticky), then IDLE. done never pulses and no rd_en or res_we is issued.
- Latency: start accepted at edge 0 gives CHECK in cycle 1, issues in cycles 2..N+1, the last res_we in cycle N+3, and done in cycle N+4.
- start while busy is ignored; dims are not re-sampled.
- All address arithmetic is done at ADDR_W+DIM_W width, then truncated. Valid dims guarantee the value fits.

Optional Feature:
- Macro: MATMUL_SEQ_CYCLE_CNT_EN.
- Defined:
  - Adds output cycle_cnt (16 bits).
  - Cleared on accepted start; increments each cycle busy=1; holds its value after DONE/ERR.
  - Saturates at 0xFFFF; reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package matmul_pkg holds:
  - state enum seq_state_t (IDLE, CHECK, RUN, DRAIN, DONE, ERR)
  - defaults for DIM_W, DATA_W, ACC_W, MAX_ELEMS
  - a dims_t struct {r1, c1, r2, c2}
- One natural sub-module: matmul_idx_counter.
  - Nested i/j/k counter with terminal-count output and address generation.
  - Top level keeps the FSM, the return-pipeline flags, and the accumulator.

Test Plan:
- 2x2 by 2x2 identity-free case: A=[1,2,3,4], B=[5,6,7,8].
  - res_we sequence: addr0=19, addr1=22, addr2=43, addr3=50.
  - done in cycle 12 after start; err=0.
- 1x1 by 1x1 (C1=1): A=[15], B=[15].
  - Single res_we with res_data=225 at addr0 in cycle 4; done in cycle 5.
- Dimension mismatch: r1=2, c1=3, r2=2, c2=2.
  - err=1 by cycle 2; no rd_en or res_we; done stays 0.
- Size overflow: r1=3, c1=3, r2=3, c2=1 gives 9 > MAX_ELEMS, so err=1.
  - A following valid start clears err.
  - Zero dim (c2=0) also sets err=1.
- Second start pulsed mid-RUN with different dims: ignored; original results and done timing unchanged.
- RST asserted in the cycle of the 3rd res_we of the 2x2 case:
  - Next cycle: all outputs 0, state IDLE, no further res_we.
  - A new start runs to normal completion.
